// File: rtl/mt_stream_prng.sv
// Parametrised Mersenne-Twister stream generator: sequential seeding sweep, in-place
// one-word-per-cycle twist, tempered output register with valid/ready back-pressure.
module mt_stream_prng #(
  parameter int           W            = 32,
  parameter int           N            = 624,
  parameter int           M            = 397,
  parameter int           R            = 31,
  parameter logic [W-1:0] A            = 32'h9908B0DF,
  parameter int           U            = 11,
  parameter logic [W-1:0] D            = 32'hFFFFFFFF,
  parameter int           S            = 7,
  parameter logic [W-1:0] B            = 32'h9D2C5680,
  parameter int           T            = 15,
  parameter logic [W-1:0] C            = 32'hEFC60000,
  parameter int           L            = 18,
  parameter logic [W-1:0] F            = 32'd1812433253,
  parameter logic [W-1:0] SEED_DEFAULT = 32'd5489
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] seed,
  input  logic         seed_valid,
  output logic         busy,
  output logic [W-1:0] rnd_data,
  output logic         rnd_valid,
  input  logic         rnd_ready
);

  localparam int           IW         = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(N - 2);
  localparam logic [W-1:0] LOWER_MASK = {{(W - R){1'b0}}, {R{1'b1}}};
  localparam logic [W-1:0] UPPER_MASK = ~LOWER_MASK;

  // busy is the FSM state itself: high exactly while in ST_INIT.
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          rnd_valid_q, rnd_valid_d;
  logic [W-1:0]  rnd_data_q, rnd_data_d;

  // x[0] carries the reset seed, so it lives apart from the unreset words 1..N-1.
  logic [W-1:0]  x0_q;
  logic [W-1:0]  xr_q [N];

  logic          we;
  logic [IW-1:0] waddr;
  logic [W-1:0]  wdata;

  logic [IW-1:0] idx_inc, idx_nxt, idx_m;
  logic [IW:0]   sum_m;
  logic [W-1:0]  x_cur, x_nxt, x_off, y_tw, twist_word, init_word;
  logic          advance;

  function automatic logic [W-1:0] temper(input logic [W-1:0] v);
    logic [W-1:0] y;
    y = v;
    y = y ^ ((y >> U) & D);
    y = y ^ ((y << S) & B);
    y = y ^ ((y << T) & C);
    y = y ^ (y >> L);
    return y;
  endfunction

  assign idx_inc = idx_q + IW'(1);
  assign idx_nxt = (idx_q == LAST_IDX) ? '0 : idx_inc;
  assign sum_m   = {1'b0, idx_q} + (IW + 1)'(M);
  assign idx_m   = (sum_m >= (IW + 1)'(N)) ? IW'(sum_m - (IW + 1)'(N)) : IW'(sum_m);

  // Reads see the array as already updated in place, which gives the reference ordering.
  assign x_cur = (idx_q   == '0) ? x0_q : xr_q[idx_q];
  assign x_nxt = (idx_nxt == '0) ? x0_q : xr_q[idx_nxt];
  assign x_off = (idx_m   == '0) ? x0_q : xr_q[idx_m];

  assign y_tw       = (x_cur & UPPER_MASK) | (x_nxt & LOWER_MASK);
  assign twist_word = x_off ^ (y_tw >> 1) ^ (y_tw[0] ? A : '0);
  assign init_word  = F * (x_cur ^ (x_cur >> (W - 2))) + W'(idx_inc);

  // Handshake: a word transfers on any edge where rnd_valid && rnd_ready; while
  // rnd_valid && !rnd_ready the word, idx and the array are frozen.
  assign advance = (state_q == ST_RUN) && (!rnd_valid_q || rnd_ready);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rnd_valid_d = rnd_valid_q;
    rnd_data_d  = rnd_data_q;
    we          = 1'b0;
    waddr       = idx_q;
    wdata       = twist_word;
    if (seed_valid) begin
      state_d     = ST_INIT;
      idx_d       = '0;
      rnd_valid_d = 1'b0;
      rnd_data_d  = '0;
      we          = 1'b1;
      waddr       = '0;
      wdata       = seed;
    end else begin
      case (state_q)
        ST_INIT: begin
          we    = 1'b1;
          waddr = idx_inc;
          wdata = init_word;
          if (idx_q == LAST_INIT) begin
            state_d = ST_RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_inc;
          end
        end
        ST_RUN: begin
          if (advance) begin
            we          = 1'b1;
            waddr       = idx_q;
            wdata       = twist_word;
            rnd_data_d  = temper(twist_word);
            rnd_valid_d = 1'b1;
            idx_d       = idx_nxt;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q <= SEED_DEFAULT;
    end else if (we && waddr == '0) begin
      x0_q <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (we && waddr != '0) begin
      xr_q[waddr] <= wdata;
    end
  end

  assign busy      = (state_q == ST_INIT);
  assign rnd_data  = rnd_data_q;
  assign rnd_valid = rnd_valid_q;

endmodule

// File: doc/mt_stream_prng.md
# mt_stream_prng

Parametrised Mersenne-Twister generator that streams tempered words over a valid/ready handshake. It is the successor to the fixed-size MT19937 core and adds three things that core lacks:
- a sequential seeding engine;
- an in-place incremental twist, one state word per cycle;
- output back-pressure.

It is configurable for any (W, N, M, R) MT variant, with MT19937 as the default. It sits beside the other RNG blocks in `rngs/hardware` and feeds stochastic-compute consumers.

## Interface
Parameters:
- W, 32, word width in bits
- N, 624, number of state words
- M, 397, twist offset (1 ≤ M < N)
- R, 31, separation point: the lower-mask width
- A, 32'h9908B0DF, twist matrix constant
- U, 11, tempering right shift u
- D, 32'hFFFFFFFF, tempering mask d
- S, 7, tempering left shift s
- B, 32'h9D2C5680, tempering mask b
- T, 15, tempering left shift t
- C, 32'hEFC60000, tempering mask c
- L, 18, tempering right shift l
- F, 1812433253, initialisation multiplier
- SEED_DEFAULT, 5489, seed loaded on reset

Ports:
- clk, in, 1, clock
- rst, in, 1, asynchronous, active-high reset
- seed, in, W, new seed value
- seed_valid, in, 1, 1-cycle request to re-seed; always accepted
- busy, out, 1, high while the initialisation sweep runs
- rnd_data, out, W, tempered random word
- rnd_valid, out, 1, rnd_data holds a valid word
- rnd_ready, in, 1, consumer accepts rnd_data

## Operation
- **State storage.** N×W word array, plus index `idx` of width $clog2(N), plus a 1-bit FSM.
- **INIT state.**
  - On seed acceptance, or on reset with SEED_DEFAULT: x[0]=seed.
  - Then one word per cycle for i=1..N-1: x[i] = F·(x[i-1] ^ (x[i-1] >> (W-2))) + i, taken mod 2^W.
  - After the last word: idx=0, go to RUN.
- **RUN state.** Advances whenever the output register is empty or is being consumed (!rnd_valid | rnd_ready). Each advance:
  - y = (x[idx] & upper(W-R)) | (x[(idx+1)%N] & lower(R))
  - x[idx] ← x[(idx+M)%N] ^ (y>>1) ^ (y[0] ? A : 0)
  - rnd_data ← temper(new x[idx]); rnd_valid ← 1
  - idx ← (idx==N-1) ? 0 : idx+1
- **Wrap-around indices.** In-place order is mandatory.
  - At idx=N-1, x[0] is the already-updated word.
  - For idx ≥ N-M, x[(idx+M)%N] is also already updated.
  - This ordering makes the output bit-exact with the reference software genrand.
- **Tempering** (all arithmetic W bits, shifts zero-fill):
  - y ^= (y>>U)&D
  - y ^= (y<<S)&B
  - y ^= (y<<T)&C
  - y ^= y>>L
- **Stall.** When rnd_valid && !rnd_ready: rnd_data, idx and the state array hold unchanged.
- **Re-seed.** seed_valid is accepted in any state and any cycle. On acceptance:
  - a pending un-consumed word is discarded;
  - next cycle rnd_valid=0, busy=1, INIT restarts from x[0]=seed.
  - If rnd_valid && rnd_ready && seed_valid occur together, that handshake completes (the word counts as delivered), then re-seed proceeds.
  - seed_valid during INIT restarts the sweep from i=1.

## Timing
- **Reset values.** rnd_valid=0, rnd_data=0, busy=1, idx=0, FSM=INIT with x[0]=SEED_DEFAULT. Array contents other than x[0] are don't-care.
- **Reset asserted mid-operation.** Outputs return to reset values immediately, asynchronously. Sweep restarts after release.
- **Seeding latency.** busy is high for exactly N-1 cycles after the accept edge, or after the first edge following reset release. rnd_valid rises on the edge after busy falls, i.e. N edges after the accept edge.
- **Throughput.** 1 word/cycle sustained when rnd_ready=1. No bubbles across the idx wrap.
- **Output stability.** rnd_data/rnd_valid are registered. Once rnd_valid=1, both stay stable until consumed or until re-seed/reset.
- **Idle consumer.** No state advance occurs without an output-register slot, so the sequence never skips.

## Test plan
- **Default seed.** Reset, rnd_ready=1, default params → first rnd_data=32'hD091BB5C (3499211612), second 581869302. rnd_valid rises N edges after reset release.
- **Seed 1 and multi-twist run.** Pulse seed_valid with seed=1 → first word 1791095845. Then stream 10000 words after a seed-5489 reset → the 10000th word is 4123659995. This covers multiple twist wraps.
- **Back-pressure.** Toggle rnd_ready pseudo-randomly (~50%) over 2000 words → accepted-word sequence identical to the rnd_ready=1 run. rnd_data never changes while rnd_valid && !rnd_ready.
- **Re-seed during RUN and INIT.** Assert seed_valid with a stalled word pending → that word is never delivered. busy=1 next cycle; output restarts at the new seed's first word. Repeat seed_valid mid-INIT → the result matches a single clean seed.
- **Simultaneous handshake and seed.** Assert rnd_valid&&rnd_ready && seed_valid together → the word is counted as delivered. The next delivered word is the new seed's first output.
- **Small variant and async reset.** Use N=8, M=3 → compare 100 words against a software model. Assert rst asynchronously between edges mid-stream → rnd_valid drops immediately; after release the sequence equals the SEED_DEFAULT sequence.
